scratchpad_bank_arbiter: RTL and testbench



---
 rtl/scratchpad_bank_arbiter.sv | 143 ++++++++++++++
 tb/tb_scratchpad_bank_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scratchpad_bank_arbiter.sv
// scratchpad_bank_arbiter
//   Crossbar between NUM_REQ OBI-style requesters and NUM_BANKS word-interleaved
//   single-port SRAM banks. Each request decodes to one bank. Per-bank conflicts
//   are resolved in the same cycle, and each bank's read data is routed back to
//   the requester that won it, one cycle later.
//
//   Build option: define SCRATCHPAD_ARB_RR_EN for round-robin arbitration with
//   one rotating pointer per bank. Without it, the lowest requester index wins.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   req_i/we_i [NUM_REQ]  request valid / write enable
//   be_i, addr_i, wdata_i per-requester byte enables, byte address, write data
//   gnt_o      [NUM_REQ]  combinational grant
//   rvalid_o   [NUM_REQ]  response valid, one cycle after the grant
//   rdata_o    [NUM_REQ]  response data (zero while rvalid_o is low)
//   bank_req_o/bank_we_o/bank_be_o/bank_addr_o/bank_wdata_o [NUM_BANKS]
//                         SRAM command per bank
//   bank_rdata_i [NUM_BANKS] SRAM read data, valid the cycle after bank_req_o
module scratchpad_bank_arbiter #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned NUM_BANKS       = 4,
  parameter int unsigned BANK_ADDR_WIDTH = 13,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ-1:0]         we_i,
  input  logic [DATA_WIDTH/8-1:0]    be_i         [NUM_REQ],
  input  logic [31:0]                addr_i       [NUM_REQ],
  input  logic [DATA_WIDTH-1:0]      wdata_i      [NUM_REQ],
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [NUM_REQ-1:0]         rvalid_o,
  output logic [DATA_WIDTH-1:0]      rdata_o      [NUM_REQ],
  output logic [NUM_BANKS-1:0]       bank_req_o,
  output logic [NUM_BANKS-1:0]       bank_we_o,
  output logic [DATA_WIDTH/8-1:0]    bank_be_o    [NUM_BANKS],
  output logic [BANK_ADDR_WIDTH-1:0] bank_addr_o  [NUM_BANKS],
  output logic [DATA_WIDTH-1:0]      bank_wdata_o [NUM_BANKS],
  input  logic [DATA_WIDTH-1:0]      bank_rdata_i [NUM_BANKS]
);

  localparam int unsigned B  = $clog2(NUM_BANKS);
  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [B-1:0]               req_bank [NUM_REQ];
  logic [BANK_ADDR_WIDTH-1:0] req_row  [NUM_REQ];
  logic [NUM_BANKS-1:0]       win_vld;
  logic [IW-1:0]              win_idx  [NUM_BANKS];
  logic [NUM_BANKS-1:0]       resp_vld;
  logic [IW-1:0]              resp_idx [NUM_BANKS];
  // Byte-offset and wrap-around address bits are deliberately ignored.
  logic                       addr_unused;

  always_comb begin
    addr_unused = 1'b0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      req_bank[r] = addr_i[r][2 +: B];
      req_row[r]  = addr_i[r][2+B +: BANK_ADDR_WIDTH];
      addr_unused = addr_unused ^ (^addr_i[r]);
    end
  end

`ifdef SCRATCHPAD_ARB_RR_EN
  logic [IW-1:0] rr_ptr [NUM_BANKS];
`endif

  // Per bank: first candidate found when scanning from the start index upward.
  always_comb begin
    logic [IW-1:0] cand;
    cand = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      win_vld[k] = 1'b0;
      win_idx[k] = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef SCRATCHPAD_ARB_RR_EN
        cand = IW'((32'(rr_ptr[k]) + i) % NUM_REQ);
`else
        cand = IW'(i);
`endif
        if (!win_vld[k] && req_i[cand] && (req_bank[cand] == B'(k))) begin
          win_vld[k] = 1'b1;
          win_idx[k] = cand;
        end
      end
    end
  end

  always_comb begin
    gnt_o      = '0;
    bank_req_o = '0;
    bank_we_o  = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      bank_be_o[k]    = '0;
      bank_addr_o[k]  = '0;
      bank_wdata_o[k] = '0;
      if (win_vld[k] && !rst_i) begin
        bank_req_o[k]        = 1'b1;
        bank_we_o[k]         = we_i[win_idx[k]];
        bank_be_o[k]         = be_i[win_idx[k]];
        bank_addr_o[k]       = req_row[win_idx[k]];
        bank_wdata_o[k]      = wdata_i[win_idx[k]];
        gnt_o[win_idx[k]]    = 1'b1;
      end
    end
  end

`ifdef SCRATCHPAD_ARB_RR_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned k = 0; k < NUM_BANKS; k++) rr_ptr[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_BANKS; k++) begin
        if (bank_req_o[k]) rr_ptr[k] <= IW'((32'(win_idx[k]) + 1) % NUM_REQ);
      end
    end
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_vld <= '0;
      for (int unsigned k = 0; k < NUM_BANKS; k++) resp_idx[k] <= '0;
    end else begin
      resp_vld <= bank_req_o;
      for (int unsigned k = 0; k < NUM_BANKS; k++) resp_idx[k] <= win_idx[k];
    end
  end

  // A requester wins at most one bank, so at most one bank routes to each port.
  always_comb begin
    rvalid_o = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) rdata_o[r] = '0;
    for (int unsigned k = 0; k < NUM_BANKS; k++) begin
      if (resp_vld[k]) begin
        rvalid_o[resp_idx[k]] = 1'b1;
        rdata_o[resp_idx[k]]  = bank_rdata_i[k];
      end
    end
  end

endmodule

// File: tb/tb_scratchpad_bank_arbiter.sv
module tb_scratchpad_bank_arbiter;
  localparam int NR    = 4;
  localparam int NB    = 4;
  localparam int BAW   = 13;
  localparam int DW    = 32;
  localparam int BEW   = DW / 8;
  localparam int ROWS  = 1 << BAW;
  localparam int TOTAL = NB * ROWS;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic [NR-1:0]     req, we;
  logic [BEW-1:0]    be     [NR];
  logic [31:0]       addr   [NR];
  logic [DW-1:0]     wdata  [NR];
  logic [NR-1:0]     gnt, rvalid;
  logic [DW-1:0]     rdata  [NR];
  logic [NB-1:0]     breq, bwe;
  logic [BEW-1:0]    bbe    [NB];
  logic [BAW-1:0]    baddr  [NB];
  logic [DW-1:0]     bwdata [NB];
  logic [DW-1:0]     brdata [NB];

  scratchpad_bank_arbiter #(
    .NUM_REQ(NR), .NUM_BANKS(NB), .BANK_ADDR_WIDTH(BAW), .DATA_WIDTH(DW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .be_i(be), .addr_i(addr),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .bank_req_o(breq), .bank_we_o(bwe), .bank_be_o(bbe), .bank_addr_o(baddr),
    .bank_wdata_o(bwdata), .bank_rdata_i(brdata)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] seed(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [BEW-1:0] m);
    logic [DW-1:0] res;
    res = old;
    for (int b = 0; b < BEW; b++) if (m[b]) res[8*b +: 8] = nw[8*b +: 8];
    return res;
  endfunction

  // Bank SRAMs: unwritten words read as seed(word) with word = row*NB + bank.
  bit [DW-1:0] sram [NB][ROWS];
  bit          swr  [NB][ROWS];

  function automatic logic [DW-1:0] sram_rd(input int k, input logic [BAW-1:0] a);
    return swr[k][a] ? sram[k][a] : seed(int'(a) * NB + k);
  endfunction

  initial forever begin
    @(posedge clk);
    for (int k = 0; k < NB; k++) begin
      if (breq[k] === 1'b1) begin
        brdata[k] <= sram_rd(k, baddr[k]);
        if (bwe[k] === 1'b1) begin
          sram[k][baddr[k]] <= merge(sram_rd(k, baddr[k]), bwdata[k], bbe[k]);
          swr[k][baddr[k]]  <= 1'b1;
        end
      end
    end
  end

  // Reference: flat word-addressed memory plus per-bank arbitration rule.
  bit [DW-1:0] fmem [TOTAL];
  bit          fwr  [TOTAL];

  function automatic int word_of(input logic [31:0] a);
    return int'((a >> 2) % 32'(TOTAL));
  endfunction

  function automatic logic [DW-1:0] frd(input int w);
    return fwr[w] ? fmem[w] : seed(w);
  endfunction

  logic [NR-1:0] m_gnt = '0;
  bit            seen_edge = 1'b0;
  initial begin
    @(posedge clk);
    seen_edge = 1'b1;
  end

  initial begin : model
    int            ptr  [NB];
    int            win  [NB];
    bit            pv   [NR];
    bit            pw   [NR];
    logic [DW-1:0] pd   [NR];
    int            best_d, d, w, r;
    logic [NR-1:0] e_gnt;
    logic [NB-1:0] e_breq, e_we;
    logic [BEW-1:0] e_be [NB];
    logic [BAW-1:0] e_row [NB];
    logic [DW-1:0]  e_wd [NB];
    for (int k = 0; k < NB; k++) ptr[k] = 0;
    for (int i = 0; i < NR; i++) begin pv[i] = 1'b0; pw[i] = 1'b0; pd[i] = '0; end
    forever begin
      @(negedge clk);
      if (seen_edge) begin
        for (int i = 0; i < NR; i++) begin
          chk($sformatf("rvalid[%0d]", i), 64'(rvalid[i]), 64'(pv[i]));
          if (!pv[i]) chk($sformatf("rdata_idle[%0d]", i), 64'(rdata[i]), 64'(0));
          else if (!pw[i]) chk($sformatf("rdata[%0d]", i), 64'(rdata[i]), 64'(pd[i]));
        end
        e_gnt = '0; e_breq = '0; e_we = '0;
        for (int k = 0; k < NB; k++) begin
          win[k] = -1;
          best_d = NR;
          e_be[k] = '0; e_row[k] = '0; e_wd[k] = '0;
          if (!rst) begin
            for (int i = 0; i < NR; i++) begin
              if (req[i] && (word_of(addr[i]) % NB == k)) begin
`ifdef SCRATCHPAD_ARB_RR_EN
                d = (i - ptr[k] + NR) % NR;
`else
                d = i;
`endif
                if (d < best_d) begin best_d = d; win[k] = i; end
              end
            end
          end
          if (win[k] >= 0) begin
            r = win[k];
            e_breq[k] = 1'b1;
            e_gnt[r]  = 1'b1;
            e_we[k]   = we[r];
            e_be[k]   = be[r];
            e_row[k]  = BAW'(word_of(addr[r]) / NB);
            e_wd[k]   = wdata[r];
          end
        end
        m_gnt = e_gnt;
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("bank_req", 64'(breq), 64'(e_breq));
        chk("bank_we", 64'(bwe), 64'(e_we));
        for (int k = 0; k < NB; k++) begin
          chk($sformatf("bank_be[%0d]", k), 64'(bbe[k]), 64'(e_be[k]));
          chk($sformatf("bank_addr[%0d]", k), 64'(baddr[k]), 64'(e_row[k]));
          chk($sformatf("bank_wdata[%0d]", k), 64'(bwdata[k]), 64'(e_wd[k]));
        end
        for (int i = 0; i < NR; i++) pv[i] = 1'b0;
        if (rst) begin
          for (int k = 0; k < NB; k++) ptr[k] = 0;
        end else begin
          for (int k = 0; k < NB; k++) begin
            if (win[k] >= 0) begin
              r = win[k];
              w = word_of(addr[r]);
              pv[r] = 1'b1;
              pw[r] = we[r];
              pd[r] = frd(w);
              if (we[r]) begin
                fmem[w] = merge(frd(w), wdata[r], be[r]);
                fwr[w]  = 1'b1;
              end
              ptr[k] = (r + 1) % NR;
            end
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic probe();
    #3;
  endtask

  task automatic idle();
    req = '0;
    we  = '0;
    for (int i = 0; i < NR; i++) begin be[i] = '0; addr[i] = '0; wdata[i] = '0; end
  endtask

  task automatic rq(input int r, input bit w, input logic [BEW-1:0] b,
                    input logic [31:0] a, input logic [DW-1:0] dat);
    req[r] = 1'b1; we[r] = w; be[r] = b; addr[r] = a; wdata[r] = dat;
  endtask

  task automatic rq_rand(input int r);
    int mode;
    logic [31:0] a;
    mode = $urandom_range(0, 9);
    if (mode < 6)      a = 32'($urandom_range(0, 63));
    else if (mode < 9) a = 32'($urandom_range(0, TOTAL * 4 - 1));
    else               a = $urandom;
    rq(r, 1'($urandom_range(0, 1)), BEW'($urandom_range(0, 15)), a, $urandom);
  endtask

  logic [NR-1:0] cexp [5];

  initial begin
`ifdef SCRATCHPAD_ARB_RR_EN
    cexp[0] = 4'b0001; cexp[1] = 4'b0010; cexp[2] = 4'b0100; cexp[3] = 4'b1000; cexp[4] = 4'b0001;
`else
    cexp[0] = 4'b0001; cexp[1] = 4'b0001; cexp[2] = 4'b0001; cexp[3] = 4'b0001; cexp[4] = 4'b0001;
`endif
    rst = 1'b1;
    idle();
    next_cycle(); probe();
    chk("reset_rvalid", 64'(rvalid), 64'(0));
    chk("reset_gnt", 64'(gnt), 64'(0));
    chk("reset_rdata0", 64'(rdata[0]), 64'(0));

    next_cycle(); rst = 1'b0; idle(); rq(0, 1'b1, 4'hF, 32'h0, 32'hDEADBEEF); probe();
    chk("preload_gnt", 64'(gnt), 64'(4'b0001));
    next_cycle(); idle();
    rq(0, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D); rq(2, 1'b1, 4'hF, 32'h14, 32'hAABBCCDD); probe();
    chk("two_bank_gnt", 64'(gnt), 64'(4'b0101));
    chk("write_rvalid", 64'(rvalid), 64'(4'b0001));
    next_cycle(); idle(); probe();
    chk("write_rvalid2", 64'(rvalid), 64'(4'b0101));

    next_cycle(); idle(); rq(0, 1'b0, 4'hF, 32'h0, '0); probe();
    chk("single_gnt", 64'(gnt), 64'(4'b0001));
    chk("single_breq", 64'(breq), 64'(4'b0001));
    chk("single_row", 64'(baddr[0]), 64'(0));
    next_cycle(); idle(); probe();
    chk("single_rvalid", 64'(rvalid), 64'(4'b0001));
    chk("single_rdata", 64'(rdata[0]), 64'(32'hDEADBEEF));

    next_cycle(); idle();
    for (int i = 0; i < NR; i++) rq(i, 1'b0, 4'hF, 32'(i * 4), '0);
    probe();
    chk("interleave_gnt", 64'(gnt), 64'(4'b1111));
    chk("interleave_breq", 64'(breq), 64'(4'b1111));
    for (int k = 0; k < NB; k++) chk($sformatf("interleave_row[%0d]", k), 64'(baddr[k]), 64'(0));

    next_cycle(); idle(); rq(0, 1'b0, 4'hF, 32'h7F00, '0); probe();
    chk("decode_7f00_breq", 64'(breq), 64'(4'b0001));
    chk("decode_7f00_row", 64'(baddr[0]), 64'(2032));
    chk("interleave_rvalid", 64'(rvalid), 64'(4'b1111));
    chk("interleave_rdata0", 64'(rdata[0]), 64'(32'hDEADBEEF));

    next_cycle(); idle(); rst = 1'b1; rq(0, 1'b0, 4'hF, 32'h4, '0); probe();
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_breq", 64'(breq), 64'(0));
    next_cycle(); rst = 1'b0; idle(); probe();
    chk("post_rst_rvalid", 64'(rvalid), 64'(0));

    for (int c = 0; c < 5; c++) begin
      next_cycle(); idle();
      for (int i = 0; i < NR; i++) rq(i, 1'b0, 4'hF, 32'(4 + 16 * i), '0);
      probe();
      chk($sformatf("conflict_gnt_c%0d", c), 64'(gnt), 64'(cexp[c]));
    end
    next_cycle(); idle(); probe();

    next_cycle(); idle(); rq(1, 1'b0, 4'hF, 32'h0, '0); probe();
    chk("b2b_gnt0", 64'(gnt), 64'(4'b0010));
    next_cycle(); idle(); rq(1, 1'b0, 4'hF, 32'h10, '0); probe();
    chk("b2b_gnt1", 64'(gnt), 64'(4'b0010));
    chk("b2b_rvalid0", 64'(rvalid), 64'(4'b0010));
    chk("b2b_rdata0", 64'(rdata[1]), 64'(32'hDEADBEEF));
    next_cycle(); idle(); probe();
    chk("b2b_rvalid1", 64'(rvalid), 64'(4'b0010));
    chk("b2b_rdata1", 64'(rdata[1]), 64'(32'hCAFEF00D));

    next_cycle(); idle(); rq(2, 1'b1, 4'b0011, 32'h14, 32'h12345678); probe();
    chk("wr_gnt", 64'(gnt), 64'(4'b0100));
    chk("wr_breq", 64'(breq), 64'(4'b0010));
    chk("wr_we", 64'(bwe), 64'(4'b0010));
    chk("wr_be", 64'(bbe[1]), 64'(4'b0011));
    chk("wr_row", 64'(baddr[1]), 64'(1));
    chk("wr_wdata", 64'(bwdata[1]), 64'(32'h12345678));
    next_cycle(); idle(); rq(2, 1'b0, 4'hF, 32'h14, '0); probe();
    chk("wr_rvalid", 64'(rvalid), 64'(4'b0100));
    next_cycle(); idle(); probe();
    chk("rd_merged_rvalid", 64'(rvalid), 64'(4'b0100));
    chk("rd_merged_data", 64'(rdata[2]), 64'(32'hAABB5678));

    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NR; i++) begin
        if (!req[i] || m_gnt[i]) begin
          if ($urandom_range(0, 9) < 7) rq_rand(i);
          else req[i] = 1'b0;
        end
      end
    end
    next_cycle(); rst = 1'b0; idle();
    next_cycle();
    next_cycle(); probe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
